// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller in front of the data cache.
// Runs one load or store at a time and returns one completion beat per op.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic        op_is_write,
   input  logic [31:0] op_addr,
   input  logic [1:0]  op_size,
   input  logic [63:0] op_wr_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic        res_fault,
   output logic        rd_req_valid,
   input  logic        rd_req_ready,
   output logic [31:0] rd_req_address,
   input  logic        rd_dp_valid,
   output logic        rd_dp_ready,
   input  logic [63:0] rd_dp_read_data,
   output logic        wr_req_valid,
   input  logic        wr_req_ready,
   output logic [31:0] wr_req_address,
   output logic [63:0] wr_req_data,
   output logic        wr_size_in,
   input  logic        page_fault
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] res_q, res_d;
   logic        fault_q, fault_d;

   function automatic logic [63:0] size_mask(
      input logic [63:0] data,
      input logic [1:0]  size
   );
      logic [63:0] m;
      m = '0;
      unique case (size)
         2'b00:   m = {56'd0, data[7:0]};
         2'b01:   m = {48'd0, data[15:0]};
         2'b10:   m = {32'd0, data[31:0]};
         default: m = data;
      endcase
      return m;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      res_d   = res_q;
      fault_d = fault_q;
      unique case (state_q)
         IDLE: begin
            if (op_valid) begin
               addr_d  = op_addr;
               size_d  = op_size;
               wdata_d = op_wr_data;
               res_d   = '0;
               fault_d = 1'b0;
               state_d = op_is_write ? WR_REQ : RD_REQ;
            end
         end
         RD_REQ: begin
            if (page_fault) begin
               res_d   = '0;
               fault_d = 1'b1;
               state_d = RESP;
            end else if (rd_req_ready) begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // a fault in the same cycle as the data beat discards the data
            if (page_fault) begin
               res_d   = '0;
               fault_d = 1'b1;
               state_d = RESP;
            end else if (rd_dp_valid) begin
               res_d   = size_mask(rd_dp_read_data, size_q);
               state_d = RESP;
            end
         end
         WR_REQ: begin
            if (page_fault) begin
               res_d   = '0;
               fault_d = 1'b1;
               state_d = RESP;
            end else if (wr_req_ready) begin
               res_d   = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         res_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         res_q   <= res_d;
         fault_q <= fault_d;
      end
   end

   assign op_ready       = (state_q == IDLE);
   assign rd_req_valid   = (state_q == RD_REQ);
   assign rd_dp_ready    = (state_q == RD_WAIT);
   assign wr_req_valid   = (state_q == WR_REQ);
   assign res_valid      = (state_q == RESP);
   assign rd_req_address = rd_req_valid ? addr_q : '0;
   assign wr_req_address = wr_req_valid ? addr_q : '0;
   assign wr_req_data    = wr_req_valid ? wdata_q : '0;
   assign wr_size_in     = wr_req_valid && (size_q == 2'b11);
   assign res_data       = res_valid ? res_q : '0;
   assign res_fault      = res_valid && fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a latency/result model.
// Scenario tasks run in sequence and compare inline.
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic        op_is_write;
   logic [31:0] op_addr;
   logic [1:0]  op_size;
   logic [63:0] op_wr_data;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic        res_fault;
   logic        rd_req_valid;
   logic        rd_req_ready;
   logic [31:0] rd_req_address;
   logic        rd_dp_valid;
   logic        rd_dp_ready;
   logic [63:0] rd_dp_read_data;
   logic        wr_req_valid;
   logic        wr_req_ready;
   logic [31:0] wr_req_address;
   logic [63:0] wr_req_data;
   logic        wr_size_in;
   logic        page_fault;

   int vectors;
   int miscompares;

   mem_access_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_is_write     (op_is_write),
      .op_addr         (op_addr),
      .op_size         (op_size),
      .op_wr_data      (op_wr_data),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_data        (res_data),
      .res_fault       (res_fault),
      .rd_req_valid    (rd_req_valid),
      .rd_req_ready    (rd_req_ready),
      .rd_req_address  (rd_req_address),
      .rd_dp_valid     (rd_dp_valid),
      .rd_dp_ready     (rd_dp_ready),
      .rd_dp_read_data (rd_dp_read_data),
      .wr_req_valid    (wr_req_valid),
      .wr_req_ready    (wr_req_ready),
      .wr_req_address  (wr_req_address),
      .wr_req_data     (wr_req_data),
      .wr_size_in      (wr_size_in),
      .page_fault      (page_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected load result: keep the low (1 << size) bytes, zero the rest.
   function automatic logic [63:0] model_load(
      input logic [63:0] d,
      input logic [1:0]  sz
   );
      int nbytes;
      logic [63:0] m;
      nbytes = 1 << sz;
      if (nbytes == 8) m = {64{1'b1}};
      else m = (64'd1 << (8 * nbytes)) - 64'd1;
      return d & m;
   endfunction

   // Expected cycle at which res_valid first appears (accept edge = 0).
   function automatic int model_lat(
      input logic wr,
      input int   req_st,
      input int   dp_st,
      input int   fph
   );
      if (wr) return 2 + req_st;
      if (fph == 1) return 2 + req_st;
      return 3 + req_st + dp_st;
   endfunction

   // Drives one op through the DUT and reports what was observed.
   // fph: 0 no fault, 1 fault with request acceptance, 2 fault with data beat.
   task automatic drive_op(
      input  logic        wr,
      input  logic [31:0] a,
      input  logic [1:0]  sz,
      input  logic [63:0] wd,
      input  logic [63:0] rd,
      input  int          req_st,
      input  int          dp_st,
      input  int          res_st,
      input  int          fph,
      output int          lat,
      output logic [63:0] d,
      output logic        f,
      output logic [31:0] qa,
      output logic [63:0] qd,
      output logic        qs,
      output logic        ok,
      output logic        tmo
   );
      int cyc;
      int k;
      logic faulted;
      ok = 1'b1; tmo = 1'b0; lat = 0; d = '0; f = 1'b0;
      cyc = 0; faulted = 1'b0;
      op_valid = 1'b1; op_is_write = wr; op_addr = a;
      op_size = sz; op_wr_data = wd;
      @(posedge clk); #1;
      op_valid = 1'b0;
      op_addr = $urandom;
      op_size = 2'($urandom);
      op_wr_data = {$urandom, $urandom};
      cyc = 1;
      qa = wr ? wr_req_address : rd_req_address;
      qd = wr_req_data;
      qs = wr_size_in;
      for (k = 0; k <= req_st; k++) begin
         if (wr) begin
            if (!wr_req_valid || rd_req_valid || rd_dp_ready) ok = 1'b0;
            if (wr_req_address !== qa || wr_req_data !== qd) ok = 1'b0;
            if (wr_size_in !== qs || rd_req_address !== 32'd0) ok = 1'b0;
         end else begin
            if (!rd_req_valid || wr_req_valid || rd_dp_ready) ok = 1'b0;
            if (rd_req_address !== qa || wr_req_address !== 32'd0) ok = 1'b0;
         end
         if (op_ready || res_valid) ok = 1'b0;
         if (k == req_st) begin
            if (wr) wr_req_ready = 1'b1;
            else rd_req_ready = 1'b1;
            if (fph == 1) begin
               page_fault = 1'b1;
               faulted = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
         wr_req_ready = 1'b0; rd_req_ready = 1'b0; page_fault = 1'b0;
      end
      if (!wr && !faulted) begin
         for (k = 0; k <= dp_st; k++) begin
            if (!rd_dp_ready || rd_req_valid || wr_req_valid) ok = 1'b0;
            if (op_ready || res_valid) ok = 1'b0;
            if (rd_req_address !== 32'd0) ok = 1'b0;
            if (k == dp_st) begin
               rd_dp_valid = 1'b1;
               rd_dp_read_data = rd;
               if (fph == 2) page_fault = 1'b1;
            end else begin
               rd_dp_read_data = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            cyc++;
            rd_dp_valid = 1'b0; page_fault = 1'b0;
            rd_dp_read_data = {$urandom, $urandom};
         end
      end
      k = 0;
      while (!res_valid && k < 8) begin
         @(posedge clk); #1;
         cyc++; k++;
      end
      if (!res_valid) begin
         tmo = 1'b1;
         return;
      end
      lat = cyc; d = res_data; f = res_fault;
      for (k = 0; k < res_st; k++) begin
         @(posedge clk); #1;
         if (!res_valid || res_data !== d || res_fault !== f) ok = 1'b0;
         if (op_ready || rd_req_valid || wr_req_valid || rd_dp_ready) ok = 1'b0;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      if (!op_ready || res_valid) ok = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      vectors++;
      if ({op_ready, res_valid, res_fault} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b exp 100", {op_ready, res_valid, res_fault});
      end
      vectors++;
      if ({rd_req_valid, rd_dp_ready, wr_req_valid, wr_size_in} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_req got %b exp 0000",
                  {rd_req_valid, rd_dp_ready, wr_req_valid, wr_size_in});
      end
      vectors++;
      if ((rd_req_address | wr_req_address) !== 32'd0 ||
          (wr_req_data | res_data) !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_data got %h/%h exp 0",
                  rd_req_address | wr_req_address, wr_req_data | res_data);
      end
   endtask

   task automatic test_load_sizes;
      logic [63:0] src;
      logic [63:0] exp;
      int lat; logic [63:0] d; logic f;
      logic [31:0] qa; logic [63:0] qd; logic qs; logic ok; logic tmo;
      src = 64'h1122_3344_5566_7788;
      drive_op(1'b0, 32'h0000_1004, 2'b10, '0, src, 0, 0, 0, 0,
               lat, d, f, qa, qd, qs, ok, tmo);
      vectors++;
      if (qa !== 32'h0000_1004) begin
         miscompares++;
         $display("FAIL load4_addr got %h exp 00001004", qa);
      end
      vectors++;
      if (d !== 64'h0000_0000_5566_7788 || f !== 1'b0) begin
         miscompares++;
         $display("FAIL load4_data got %h f=%b exp 0000000055667788 f=0", d, f);
      end
      vectors++;
      if (lat !== 3 || tmo !== 1'b0 || ok !== 1'b1) begin
         miscompares++;
         $display("FAIL load4_lat got %0d tmo=%b ok=%b exp 3 0 1", lat, tmo, ok);
      end
      for (int s = 0; s < 4; s++) begin
         if (s == 2) continue;
         drive_op(1'b0, 32'h0000_0040 + 32'(s), 2'(s), '0, src, 0, 0, 0, 0,
                  lat, d, f, qa, qd, qs, ok, tmo);
         exp = (s == 0) ? 64'h88 : (s == 1) ? 64'h7788 : src;
         vectors++;
         if (d !== exp || f !== 1'b0 || ok !== 1'b1 || tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL load_size%0d got %h ok=%b exp %h", s, d, ok, exp);
         end
      end
   endtask

   task automatic test_store_stall;
      int lat; logic [63:0] d; logic f;
      logic [31:0] qa; logic [63:0] qd; logic qs; logic ok; logic tmo;
      drive_op(1'b1, 32'h0000_2000, 2'b11, 64'hDEAD_BEEF_CAFE_F00D, '0,
               4, 0, 0, 0, lat, d, f, qa, qd, qs, ok, tmo);
      vectors++;
      if (qa !== 32'h2000 || qd !== 64'hDEAD_BEEF_CAFE_F00D || qs !== 1'b1) begin
         miscompares++;
         $display("FAIL store_req got %h %h %b exp 00002000 deadbeefcafef00d 1",
                  qa, qd, qs);
      end
      vectors++;
      if (ok !== 1'b1 || tmo !== 1'b0 || lat !== 6) begin
         miscompares++;
         $display("FAIL store_stall got lat=%0d ok=%b tmo=%b exp 6 1 0", lat, ok, tmo);
      end
      vectors++;
      if (d !== 64'd0 || f !== 1'b0) begin
         miscompares++;
         $display("FAIL store_res got %h f=%b exp 0 f=0", d, f);
      end
      drive_op(1'b1, 32'h0000_3002, 2'b01, 64'h0123_4567_89AB_CDEF, '0,
               0, 0, 0, 0, lat, d, f, qa, qd, qs, ok, tmo);
      vectors++;
      if (qs !== 1'b0 || lat !== 2 || ok !== 1'b1) begin
         miscompares++;
         $display("FAIL store2 got size=%b lat=%0d ok=%b exp 0 2 1", qs, lat, ok);
      end
   endtask

   task automatic test_fault;
      int lat; logic [63:0] d; logic f;
      logic [31:0] qa; logic [63:0] qd; logic qs; logic ok; logic tmo;
      drive_op(1'b0, 32'h0000_5008, 2'b11, '0, 64'hFFFF_FFFF_FFFF_FFFF,
               0, 2, 0, 2, lat, d, f, qa, qd, qs, ok, tmo);
      vectors++;
      if (f !== 1'b1 || d !== 64'd0) begin
         miscompares++;
         $display("FAIL fault_dp got f=%b %h exp 1 0", f, d);
      end
      vectors++;
      if (ok !== 1'b1 || tmo !== 1'b0 || lat !== 5) begin
         miscompares++;
         $display("FAIL fault_dp_flow got lat=%0d ok=%b exp 5 1", lat, ok);
      end
      drive_op(1'b1, 32'h0000_6000, 2'b10, 64'h55, '0,
               1, 0, 0, 1, lat, d, f, qa, qd, qs, ok, tmo);
      vectors++;
      if (f !== 1'b1 || d !== 64'd0 || lat !== 3 || ok !== 1'b1) begin
         miscompares++;
         $display("FAIL fault_wr got f=%b %h lat=%0d exp 1 0 3", f, d, lat);
      end
   endtask

   task automatic test_res_stall;
      int lat; logic [63:0] d; logic f;
      logic [31:0] qa; logic [63:0] qd; logic qs; logic ok; logic tmo;
      drive_op(1'b0, 32'h0000_7000, 2'b10, '0, 64'hA5A5_5A5A_1234_5678,
               0, 0, 5, 0, lat, d, f, qa, qd, qs, ok, tmo);
      vectors++;
      if (ok !== 1'b1 || d !== 64'h1234_5678 || tmo !== 1'b0) begin
         miscompares++;
         $display("FAIL res_stall got %h ok=%b exp 12345678 1", d, ok);
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      op_valid = 1'b1; op_is_write = 1'b0;
      op_addr = 32'h0000_8000; op_size = 2'b10;
      @(posedge clk); #1;
      op_valid = 1'b0;
      vectors++;
      if (rd_req_valid !== 1'b1 || rd_req_address !== 32'h8000) begin
         miscompares++;
         $display("FAIL rst_mid_req got %b %h exp 1 00008000",
                  rd_req_valid, rd_req_address);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++;
      if ({op_ready, res_valid, rd_req_valid, rd_dp_ready, wr_req_valid} !== 5'b10000 ||
          rd_req_address !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_mid_out got %b %h exp 10000 0",
                  {op_ready, res_valid, rd_req_valid, rd_dp_ready, wr_req_valid},
                  rd_req_address);
      end
      seen = 1'b0;
      rd_req_ready = 1'b1; rd_dp_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (res_valid || rd_req_valid) seen = 1'b1;
      end
      rd_req_ready = 1'b0; rd_dp_valid = 1'b0;
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_beat got %b exp 0", seen);
      end
   endtask

   task automatic test_random;
      int lat; logic [63:0] d; logic f;
      logic [31:0] qa; logic [63:0] qd; logic qs; logic ok; logic tmo;
      logic wr; logic [31:0] a; logic [1:0] sz; logic [63:0] wd, rd;
      int rq, dp, rs, fph, elat;
      logic [63:0] ed;
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom); a = $urandom; sz = 2'($urandom);
         wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
         rq = $urandom_range(0, 3); dp = $urandom_range(0, 3);
         rs = $urandom_range(0, 2);
         fph = ($urandom_range(0, 7) == 0) ? (wr ? 1 : $urandom_range(1, 2)) : 0;
         drive_op(wr, a, sz, wd, rd, rq, dp, rs, fph,
                  lat, d, f, qa, qd, qs, ok, tmo);
         if (tmo) begin
            vectors++; miscompares++;
            $display("FAIL rnd%0d_timeout", n);
            reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
            continue;
         end
         elat = model_lat(wr, rq, dp, fph);
         ed = (wr || fph != 0) ? 64'd0 : model_load(rd, sz);
         vectors++;
         if (d !== ed || f !== (fph != 0)) begin
            miscompares++;
            $display("FAIL rnd%0d_res got %h f=%b exp %h f=%b", n, d, f, ed, fph != 0);
         end
         vectors++;
         if (lat !== elat || ok !== 1'b1) begin
            miscompares++;
            $display("FAIL rnd%0d_flow got lat=%0d ok=%b exp %0d 1", n, lat, ok, elat);
         end
         vectors++;
         if (qa !== a) begin
            miscompares++;
            $display("FAIL rnd%0d_addr got %h exp %h", n, qa, a);
         end
         if (wr) begin
            vectors++;
            if (qd !== wd || qs !== (sz == 2'b11)) begin
               miscompares++;
               $display("FAIL rnd%0d_wdata got %h %b exp %h %b", n, qd, qs, wd, sz == 2'b11);
            end
         end
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      reset = 1'b1; op_valid = 1'b0; op_is_write = 1'b0;
      op_addr = '0; op_size = '0; op_wr_data = '0;
      res_ready = 1'b0; rd_req_ready = 1'b0; rd_dp_valid = 1'b0;
      rd_dp_read_data = '0; wr_req_ready = 1'b0; page_fault = 1'b0;
      test_reset;
      test_load_sizes;
      test_store_stall;
      test_fault;
      test_res_stall;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
